// File: rtl/riscv_multicycle_controller.sv
// Main FSM and ALU/branch decoder for the shared-ALU multicycle RV32I datapath.
// Define BRANCH_EXT_EN to add bne/blt/bge decoding in the BRANCH state.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_JAL, S_JALR1, S_JALR2, S_BRANCH, S_LUI
  } state_t;

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_RTYPE = 7'b0110011,
    OP_IALU  = 7'b0010011,
    OP_BRAN  = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111
  } opcode_t;

  state_t     state, state_next, cur;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;
  logic       funct_bad, pc_update, branch, take, illegal_int;

`ifndef BRANCH_EXT_EN
  logic unused_neg;
  assign unused_neg = Neg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_IALU, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                  ImmSrc = 3'b001;
      OP_BRAN:                   ImmSrc = 3'b010;
      OP_JAL:                    ImmSrc = 3'b011;
      OP_LUI:                    ImmSrc = 3'b100;
      default:                   ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    alu_dec   = 3'b000;
    funct_bad = 1'b0;
    case (funct3)
      3'b000:  alu_dec = (op == OP_RTYPE && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: funct_bad = 1'b1;
    endcase
  end

  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    take        = 1'b0;
    illegal_int = 1'b0;
    // During reset the outputs track FETCH; enables are masked below.
    cur         = rst ? S_FETCH : state;
    state_next  = S_FETCH;
    case (cur)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_IALU:           state_next = S_EXECI;
          OP_BRAN:           state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR1;
          OP_LUI:            state_next = S_LUI;
          default:           illegal_int = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD:  begin AdrSrc = 1'b1; state_next = S_MEMWB; end
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR, S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = (cur == S_EXECI) ? 2'b01 : 2'b00; alu_op = 2'b10;
        // A bad funct3 abandons the instruction before ALUWB can write back.
        illegal_int = funct_bad;
        state_next  = funct_bad ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL, S_JALR2: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR1: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; state_next = S_JALR2; end
      S_BRANCH: begin
        ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1;
        case (funct3)
          3'b000:  take = Zero;
`ifdef BRANCH_EXT_EN
          3'b001:  take = !Zero;
          3'b100:  take = Neg;
          3'b101:  take = !Neg;
`endif
          default: illegal_int = 1'b1;
        endcase
      end
      S_LUI:   begin ResultSrc = 2'b11; RegWrite = 1'b1; end
      default: state_next = S_FETCH;
    endcase

    case (alu_op)
      2'b01:   ALUControl = 3'b001;
      2'b10:   ALUControl = alu_dec;
      default: ALUControl = 3'b000;
    endcase

    PCWrite = pc_update | (branch & take);
    Illegal = illegal_int;
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller; expectations follow BRANCH_EXT_EN.
module tb_riscv_multicycle_controller;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [13:0] obs;
  int errors = 0;
  int checks = 0;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  localparam logic [13:0] V_RST      = 14'b0_0_0_0_0_10_00_10_000;
  localparam logic [13:0] V_FETCH    = 14'b1_0_0_1_0_10_00_10_000;
  localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_00_01_01_000;
  localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_00_10_01_000;
  localparam logic [13:0] V_MEMREAD  = 14'b0_1_0_0_0_00_00_00_000;
  localparam logic [13:0] V_MEMWB    = 14'b0_0_0_0_1_01_00_00_000;
  localparam logic [13:0] V_MEMWRITE = 14'b0_1_1_0_0_00_00_00_000;
  localparam logic [13:0] V_EXECR_SUB= 14'b0_0_0_0_0_00_10_00_001;
  localparam logic [13:0] V_EXECR_ADD= 14'b0_0_0_0_0_00_10_00_000;
  localparam logic [13:0] V_EXECI_ADD= 14'b0_0_0_0_0_00_10_01_000;
  localparam logic [13:0] V_ALUWB    = 14'b0_0_0_0_1_00_00_00_000;
  localparam logic [13:0] V_JAL      = 14'b1_0_0_0_0_00_01_10_000;
  localparam logic [13:0] V_JALR1    = 14'b0_0_0_0_0_00_10_01_000;
  localparam logic [13:0] V_BR_TAKEN = 14'b1_0_0_0_0_00_10_00_001;
  localparam logic [13:0] V_BR_NOT   = 14'b0_0_0_0_0_00_10_00_001;
  localparam logic [13:0] V_LUI      = 14'b0_0_0_0_1_11_00_00_000;

  riscv_multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; Neg = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== V_RST) begin errors++; $display("FAIL reset_hold ctrl=%b expected %b", obs, V_RST); end
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", Illegal); end
    rst = 1'b0; #1;
    checks++;
    if (obs !== V_FETCH) begin errors++; $display("FAIL first_fetch ctrl=%b expected %b", obs, V_FETCH); end
    tick(); tick(); tick();
    checks++;
    if (obs !== V_MEMWRITE) begin errors++; $display("FAIL pre_reset_memwrite ctrl=%b expected %b", obs, V_MEMWRITE); end
    rst = 1'b1; #1;
    checks++;
    if (obs !== V_RST) begin errors++; $display("FAIL reset_in_memwrite ctrl=%b expected %b", obs, V_RST); end
    tick();
    rst = 1'b0; #1;
    checks++;
    if (obs !== V_FETCH) begin errors++; $display("FAIL fetch_after_reset ctrl=%b expected %b", obs, V_FETCH); end
  endtask

  task automatic test_lw();
    logic [13:0] exp [6] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_FETCH};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; Neg = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL lw step%0d ctrl=%b expected %b", i, obs, exp[i]); end
      checks++;
      if (ImmSrc !== 3'b000 || Illegal !== 1'b0) begin errors++;
        $display("FAIL lw_imm step%0d imm=%b ill=%b expected 000/0", i, ImmSrc, Illegal); end
    end
  endtask

  task automatic test_sw();
    logic [13:0] exp [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE, V_FETCH};
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL sw step%0d ctrl=%b expected %b", i, obs, exp[i]); end
      checks++;
      if (ImmSrc !== 3'b001 || Illegal !== 1'b0) begin errors++;
        $display("FAIL sw_imm step%0d imm=%b ill=%b expected 001/0", i, ImmSrc, Illegal); end
    end
  endtask

  task automatic test_rtype_sub();
    logic [13:0] exp [5] = '{V_FETCH, V_DECODE, V_EXECR_SUB, V_ALUWB, V_FETCH};
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== 1'b0) begin errors++;
        $display("FAIL rsub step%0d ctrl=%b ill=%b expected %b/0", i, obs, Illegal, exp[i]); end
    end
  endtask

  task automatic test_addi_f7();
    logic [13:0] exp [5] = '{V_FETCH, V_DECODE, V_EXECI_ADD, V_ALUWB, V_FETCH};
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== 1'b0 || ImmSrc !== 3'b000) begin errors++;
        $display("FAIL addi step%0d ctrl=%b ill=%b imm=%b expected %b/0/000", i, obs, Illegal, ImmSrc, exp[i]); end
    end
  endtask

  task automatic test_bad_funct3();
    logic [13:0] exp [4] = '{V_FETCH, V_DECODE, V_EXECR_ADD, V_FETCH};
    logic [0:3]  ill = 4'b0010;
    op = 7'b0110011; funct3 = 3'b001; funct7b5 = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== ill[i]) begin errors++;
        $display("FAIL badf3 step%0d ctrl=%b ill=%b expected %b/%b", i, obs, Illegal, exp[i], ill[i]); end
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic n,
                             input logic [13:0] br_exp, input logic br_ill);
    logic [13:0] exp [4];
    logic [0:3]  ill;
    exp = '{V_FETCH, V_DECODE, br_exp, V_FETCH};
    ill = {2'b00, br_ill, 1'b0};
    op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0; Zero = z; Neg = n; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== ill[i] || ImmSrc !== 3'b010) begin errors++;
        $display("FAIL branch f3=%b z=%b n=%b step%0d ctrl=%b ill=%b imm=%b expected %b/%b/010",
                 f3, z, n, i, obs, Illegal, ImmSrc, exp[i], ill[i]); end
    end
    Zero = 1'b0; Neg = 1'b0;
  endtask

  task automatic test_jal();
    logic [13:0] exp [5] = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB, V_FETCH};
    op = 7'b1101111; funct3 = 3'b000; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== 1'b0 || ImmSrc !== 3'b011) begin errors++;
        $display("FAIL jal step%0d ctrl=%b ill=%b imm=%b expected %b/0/011", i, obs, Illegal, ImmSrc, exp[i]); end
    end
  endtask

  task automatic test_jalr();
    logic [13:0] exp [6] = '{V_FETCH, V_DECODE, V_JALR1, V_JAL, V_ALUWB, V_FETCH};
    op = 7'b1100111; funct3 = 3'b000; #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== 1'b0 || ImmSrc !== 3'b000) begin errors++;
        $display("FAIL jalr step%0d ctrl=%b ill=%b imm=%b expected %b/0/000", i, obs, Illegal, ImmSrc, exp[i]); end
    end
  endtask

  task automatic test_lui();
    logic [13:0] exp [4] = '{V_FETCH, V_DECODE, V_LUI, V_FETCH};
    op = 7'b0110111; funct3 = 3'b000; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== 1'b0 || ImmSrc !== 3'b100) begin errors++;
        $display("FAIL lui step%0d ctrl=%b ill=%b imm=%b expected %b/0/100", i, obs, Illegal, ImmSrc, exp[i]); end
    end
  endtask

  task automatic test_illegal_op();
    logic [13:0] exp [4] = '{V_FETCH, V_DECODE, V_FETCH, V_DECODE};
    logic [0:3]  ill = 4'b0101;
    op = 7'b1111111; funct3 = 3'b000; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i] || Illegal !== ill[i] || ImmSrc !== 3'b000) begin errors++;
        $display("FAIL illop step%0d ctrl=%b ill=%b imm=%b expected %b/%b/000", i, obs, Illegal, ImmSrc, exp[i], ill[i]); end
    end
    op = 7'b0110111; #1;
    tick();  // DECODE with lui -> LUI
    tick();  // LUI -> FETCH
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_addi_f7();
    test_bad_funct3();
    test_branch(3'b000, 1'b1, 1'b0, V_BR_TAKEN, 1'b0);
    test_branch(3'b000, 1'b0, 1'b1, V_BR_NOT,   1'b0);
`ifdef BRANCH_EXT_EN
    test_branch(3'b001, 1'b0, 1'b0, V_BR_TAKEN, 1'b0);
    test_branch(3'b100, 1'b0, 1'b1, V_BR_TAKEN, 1'b0);
    test_branch(3'b101, 1'b0, 1'b1, V_BR_NOT,   1'b0);
`else
    test_branch(3'b001, 1'b0, 1'b0, V_BR_NOT,   1'b1);
    test_branch(3'b100, 1'b0, 1'b1, V_BR_NOT,   1'b1);
`endif
    test_jal();
    test_jalr();
    test_lui();
    test_illegal_op();
    checks++;
    if (obs !== V_FETCH) begin errors++; $display("FAIL final_fetch ctrl=%b expected %b", obs, V_FETCH); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
